// File: rtl/atm_pkg.sv
// Shared ATM definitions: note units, error codes and ledger FSM states.
// Used by the front panel and the account/cassette back end.
package atm_pkg;

  localparam logic [2:0] U_50000  = 3'd1;
  localparam logic [2:0] U_100000 = 3'd2;
  localparam logic [2:0] U_200000 = 3'd4;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_FUNDS = 3'd1;
  localparam logic [2:0] ERR_STOCK = 3'd2;
  localparam logic [2:0] ERR_OVF   = 3'd3;
  localparam logic [2:0] ERR_MULTI = 3'd4;
  localparam logic [2:0] ERR_BUSY  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DISPENSE,
    S_GAP,
    S_FIN
  } state_e;

endpackage

// File: rtl/atm_ledger_if.sv
// Request pulses from the front panel and ledger status back to it.
// master = front panel side, slave = ledger side.
interface atm_ledger_if #(
  parameter int unsigned BAL_W   = 16,
  parameter int unsigned STOCK_W = 8
);
  logic               W_50000;
  logic               W_100000;
  logic               W_200000;
  logic               D_50000;
  logic               D_100000;
  logic               D_200000;
  logic [BAL_W-1:0]   balance;
  logic [STOCK_W-1:0] stock;
  logic               busy;
  logic               note_out;
  logic               done;
  logic               err;
  logic [2:0]         err_code;

  modport master (
    output W_50000, W_100000, W_200000,
    output D_50000, D_100000, D_200000,
    input  balance, stock, busy,
    input  note_out, done, err, err_code
  );

  modport slave (
    input  W_50000, W_100000, W_200000,
    input  D_50000, D_100000, D_200000,
    output balance, stock, busy,
    output note_out, done, err, err_code
  );
endinterface

// File: rtl/atm_req_decode.sv
// Maps the six request pulses to kind, unit count and a collision flag.
// units is only meaningful when req_valid is high.
module atm_req_decode
  import atm_pkg::*;
(
  input  logic       w_50000,
  input  logic       w_100000,
  input  logic       w_200000,
  input  logic       d_50000,
  input  logic       d_100000,
  input  logic       d_200000,
  output logic       req_valid,
  output logic       is_withdraw,
  output logic [2:0] units,
  output logic       multi
);

  logic [5:0] req;

  assign req = {d_200000, d_100000, d_50000,
                w_200000, w_100000, w_50000};

  always_comb begin
    multi       = ($countones(req) > 1);
    req_valid   = (req != 6'd0) && !multi;
    is_withdraw = |req[2:0];
    units       = 3'd0;
    if (req_valid) begin
      unique case (1'b1)
        req[0], req[3]: units = U_50000;
        req[1], req[4]: units = U_100000;
        default:        units = U_200000;
      endcase
    end
  end

endmodule

// File: rtl/atm_ledger.sv
// Account and cassette ledger: validates requests, updates balance/stock
// and paces 50000-note dispense pulses to the cassette motor.
module atm_ledger
  import atm_pkg::*;
#(
  parameter int unsigned INIT_BALANCE = 20,
  parameter int unsigned INIT_STOCK   = 8,
  parameter int unsigned BAL_W        = 16,
  parameter int unsigned STOCK_W      = 8,
  parameter int unsigned NOTE_GAP     = 2
) (
  input logic         clock,
  input logic         reset,
  atm_ledger_if.slave bus
);

  localparam int unsigned GAP_W =
    (NOTE_GAP < 2) ? 1 : $clog2(NOTE_GAP);

  state_e             state_q, state_d;
  logic               is_wd_q, is_wd_d;
  logic [2:0]         units_q, units_d;
  logic [2:0]         rem_q, rem_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [BAL_W-1:0]   bal_q, bal_d;
  logic [STOCK_W-1:0] stk_q, stk_d;
  logic               note_q, note_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [2:0]         code_q, code_d;

  logic               req_valid, req_wd, req_multi;
  logic [2:0]         req_units;
  logic               funds_ok, stock_ok, ovf, busy_viol;
  logic [BAL_W:0]     bal_sum;
  logic [STOCK_W:0]   stk_sum;

  atm_req_decode u_dec (
    .w_50000     (bus.W_50000),
    .w_100000    (bus.W_100000),
    .w_200000    (bus.W_200000),
    .d_50000     (bus.D_50000),
    .d_100000    (bus.D_100000),
    .d_200000    (bus.D_200000),
    .req_valid   (req_valid),
    .is_withdraw (req_wd),
    .units       (req_units),
    .multi       (req_multi)
  );

  assign funds_ok  = bal_q >= BAL_W'(units_q);
  assign stock_ok  = stk_q >= STOCK_W'(units_q);
  assign bal_sum   = {1'b0, bal_q} + (BAL_W+1)'(units_q);
  assign stk_sum   = {1'b0, stk_q} + (STOCK_W+1)'(units_q);
  assign ovf       = bal_sum[BAL_W] | stk_sum[STOCK_W];
  assign busy_viol = (state_q != S_IDLE) &&
                     (req_valid || req_multi);

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (req_valid) state_d = S_CHECK;
      S_CHECK:
        state_d = (is_wd_q && funds_ok && stock_ok) ?
                  S_DISPENSE : S_IDLE;
      S_DISPENSE:
        state_d = (rem_q == 3'd1) ? S_FIN : S_GAP;
      S_GAP:
        if (gap_q == GAP_W'(NOTE_GAP - 1)) state_d = S_DISPENSE;
      S_FIN:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    is_wd_d = is_wd_q;
    units_d = units_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    bal_d   = bal_q;
    stk_d   = stk_q;
    code_d  = code_q;
    note_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          is_wd_d = req_wd;
          units_d = req_units;
        end else if (req_multi) begin
          err_d  = 1'b1;
          code_d = ERR_MULTI;
        end
      end
      S_CHECK: begin
        if (is_wd_q) begin
          if (!funds_ok) begin
            err_d  = 1'b1;
            code_d = ERR_FUNDS;
          end else if (!stock_ok) begin
            err_d  = 1'b1;
            code_d = ERR_STOCK;
          end else begin
            bal_d = bal_q - BAL_W'(units_q);
            stk_d = stk_q - STOCK_W'(units_q);
            rem_d = units_q;
          end
        end else if (ovf) begin
          err_d  = 1'b1;
          code_d = ERR_OVF;
        end else begin
          bal_d  = bal_sum[BAL_W-1:0];
          stk_d  = stk_sum[STOCK_W-1:0];
          done_d = 1'b1;
          code_d = ERR_NONE;
        end
      end
      S_DISPENSE: begin
        note_d = 1'b1;
        rem_d  = rem_q - 3'd1;
        gap_d  = '0;
      end
      S_GAP:
        gap_d = gap_q + GAP_W'(1);
      S_FIN: begin
        done_d = 1'b1;
        code_d = ERR_NONE;
      end
      default: ;
    endcase
    // the operation's own done/err outranks a stray request while busy
    if (busy_viol && !done_d && !err_d) begin
      err_d  = 1'b1;
      code_d = ERR_BUSY;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      is_wd_q <= 1'b0;
      units_q <= 3'd0;
      rem_q   <= 3'd0;
      gap_q   <= '0;
      bal_q   <= BAL_W'(INIT_BALANCE);
      stk_q   <= STOCK_W'(INIT_STOCK);
      note_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      is_wd_q <= is_wd_d;
      units_q <= units_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      bal_q   <= bal_d;
      stk_q   <= stk_d;
      note_q  <= note_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign bus.balance  = bal_q;
  assign bus.stock    = stk_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.note_out = note_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.err_code = code_q;

endmodule

// File: tb/tb_atm_ledger.sv
// Ledger bench: directed scenarios plus random pulses checked every cycle
// against a transaction-level schedule of expected events.
module tb_atm_ledger;

  localparam int INIT_B = 20;
  localparam int INIT_S = 8;
  localparam int BW     = 16;
  localparam int SW     = 8;
  localparam int G      = 2;
  localparam int MAXC   = 4000;

  localparam logic [5:0] R_W50  = 6'b000001;
  localparam logic [5:0] R_W100 = 6'b000010;
  localparam logic [5:0] R_W200 = 6'b000100;
  localparam logic [5:0] R_D50  = 6'b001000;
  localparam logic [5:0] R_D100 = 6'b010000;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  atm_ledger_if #(.BAL_W(BW), .STOCK_W(SW)) bus1();
  atm_ledger_if #(.BAL_W(BW), .STOCK_W(SW)) bus2();

  atm_ledger #(
    .INIT_BALANCE(INIT_B), .INIT_STOCK(INIT_S),
    .BAL_W(BW), .STOCK_W(SW), .NOTE_GAP(G)
  ) dut1 (
    .clock(clock), .reset(reset), .bus(bus1)
  );

  atm_ledger #(
    .INIT_BALANCE(3), .INIT_STOCK(254),
    .BAL_W(BW), .STOCK_W(SW), .NOTE_GAP(G)
  ) dut2 (
    .clock(clock), .reset(reset), .bus(bus2)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  bit e_note[MAXC];
  bit e_done[MAXC];
  bit e_err[MAXC];
  bit e_busy[MAXC];
  int e_code[MAXC];
  int e_bal[MAXC];
  int e_stk[MAXC];

  int cur_code, cur_bal, cur_stk;
  int m_bal, m_stk, idle_from;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cyc %0d: got %0d want %0d",
               tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_after(input int c);
    for (int i = c + 1; i < MAXC; i++) begin
      e_note[i] = 1'b0;
      e_done[i] = 1'b0;
      e_err[i]  = 1'b0;
      e_busy[i] = 1'b0;
      e_code[i] = -1;
      e_bal[i]  = -1;
      e_stk[i]  = -1;
    end
  endtask

  task automatic model(input logic [5:0] r, input bit rst);
    int n, idx, u, d;
    if (rst) begin
      clear_after(cyc);
      e_bal[cyc+1]  = INIT_B;
      e_stk[cyc+1]  = INIT_S;
      e_code[cyc+1] = 0;
      m_bal = INIT_B;
      m_stk = INIT_S;
      idle_from = cyc + 1;
      return;
    end
    n = $countones(r);
    if (n == 0) return;
    if (cyc < idle_from) begin
      if (cyc + 1 != idle_from) begin
        e_err[cyc+1]  = 1'b1;
        e_code[cyc+1] = 5;
      end
      return;
    end
    if (n > 1) begin
      e_err[cyc+1]  = 1'b1;
      e_code[cyc+1] = 4;
      return;
    end
    idx = 0;
    for (int i = 0; i < 6; i++) if (r[i]) idx = i;
    u = 1 << (idx % 3);
    e_busy[cyc+1] = 1'b1;
    idle_from = cyc + 2;
    if (idx < 3) begin
      if (m_bal < u) begin
        e_err[cyc+2]  = 1'b1;
        e_code[cyc+2] = 1;
      end else if (m_stk < u) begin
        e_err[cyc+2]  = 1'b1;
        e_code[cyc+2] = 2;
      end else begin
        m_bal -= u;
        m_stk -= u;
        e_bal[cyc+2] = m_bal;
        e_stk[cyc+2] = m_stk;
        for (int k = 0; k < u; k++) e_note[cyc + 3 + k*(G+1)] = 1'b1;
        d = cyc + 3 + (u - 1)*(G + 1) + 1;
        for (int i = cyc + 1; i < d; i++) e_busy[i] = 1'b1;
        e_done[d] = 1'b1;
        e_code[d] = 0;
        idle_from = d;
      end
    end else begin
      if (m_bal + u > (1 << BW) - 1 || m_stk + u > (1 << SW) - 1) begin
        e_err[cyc+2]  = 1'b1;
        e_code[cyc+2] = 3;
      end else begin
        m_bal += u;
        m_stk += u;
        e_bal[cyc+2]  = m_bal;
        e_stk[cyc+2]  = m_stk;
        e_done[cyc+2] = 1'b1;
        e_code[cyc+2] = 0;
      end
    end
  endtask

  task automatic cycle(input logic [5:0] r, input bit rst);
    if (e_code[cyc] >= 0) cur_code = e_code[cyc];
    if (e_bal[cyc] >= 0)  cur_bal  = e_bal[cyc];
    if (e_stk[cyc] >= 0)  cur_stk  = e_stk[cyc];
    chk("note_out", bus1.note_out, e_note[cyc]);
    chk("done",     bus1.done,     e_done[cyc]);
    chk("err",      bus1.err,      e_err[cyc]);
    chk("busy",     bus1.busy,     e_busy[cyc]);
    chk("err_code", bus1.err_code, cur_code);
    chk("balance",  bus1.balance,  cur_bal);
    chk("stock",    bus1.stock,    cur_stk);
    bus1.W_50000  = r[0];
    bus1.W_100000 = r[1];
    bus1.W_200000 = r[2];
    bus1.D_50000  = r[3];
    bus1.D_100000 = r[4];
    bus1.D_200000 = r[5];
    reset = rst;
    model(r, rst);
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(6'd0, 1'b0);
  endtask

  initial begin
    logic [5:0] r;
    int a, b;
    clear_after(-1);
    cur_code = 0;
    cur_bal  = INIT_B;
    cur_stk  = INIT_S;
    m_bal    = INIT_B;
    m_stk    = INIT_S;
    idle_from = 0;
    {bus1.W_50000, bus1.W_100000, bus1.W_200000} = 3'b000;
    {bus1.D_50000, bus1.D_100000, bus1.D_200000} = 3'b000;
    {bus2.W_50000, bus2.W_100000, bus2.W_200000} = 3'b000;
    {bus2.D_50000, bus2.D_100000, bus2.D_200000} = 3'b000;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    cycle(6'd0, 1'b1);
    idle(2);
    cycle(R_W200, 1'b0);
    idle(16);
    chk("w200_bal", bus1.balance, 16);
    chk("w200_stk", bus1.stock, 4);

    cycle(6'd0, 1'b1);
    idle(1);
    cycle(R_W200, 1'b0);
    idle(12);
    cycle(R_W200, 1'b0);
    idle(12);
    cycle(R_W200, 1'b0);
    idle(3);
    chk("w3_code", bus1.err_code, 2);
    chk("w3_bal", bus1.balance, 12);
    chk("w3_stk", bus1.stock, 0);
    cycle(R_D50, 1'b0);
    idle(3);
    chk("w3_dep_code", bus1.err_code, 0);
    chk("w3_dep_stk", bus1.stock, 1);

    cycle(6'd0, 1'b1);
    idle(1);
    cycle(R_D100, 1'b0);
    idle(3);
    chk("d100_bal", bus1.balance, 22);
    chk("d100_stk", bus1.stock, 10);

    cycle(6'd0, 1'b1);
    idle(1);
    cycle(R_W50 | R_D50, 1'b0);
    idle(2);
    chk("multi_code", bus1.err_code, 4);
    chk("multi_bal", bus1.balance, 20);

    cycle(6'd0, 1'b1);
    idle(1);
    cycle(R_W200, 1'b0);
    idle(4);
    cycle(R_D50, 1'b0);
    idle(10);
    cycle(6'd0, 1'b1);
    idle(1);
    cycle(R_W200, 1'b0);
    idle(4);
    cycle(R_D50, 1'b0);
    idle(1);
    cycle(6'd0, 1'b1);
    idle(8);

    for (int i = 0; i < 1500; i++) begin
      a = $urandom_range(0, 99);
      r = 6'd0;
      if (a >= 80 && a < 95) begin
        r[$urandom_range(0, 5)] = 1'b1;
      end else if (a >= 95) begin
        a = $urandom_range(0, 5);
        b = (a + $urandom_range(1, 5)) % 6;
        r[a] = 1'b1;
        r[b] = 1'b1;
      end
      cycle(r, $urandom_range(0, 299) == 0);
    end

    cycle(6'd0, 1'b1);
    idle(1);
    bus2.W_200000 = 1'b1;
    cycle(6'd0, 1'b0);
    bus2.W_200000 = 1'b0;
    chk("b2_err_early", bus2.err, 0);
    cycle(6'd0, 1'b0);
    chk("b2_funds_err", bus2.err, 1);
    chk("b2_funds_code", bus2.err_code, 1);
    chk("b2_funds_bal", bus2.balance, 3);
    bus2.D_50000 = 1'b1;
    cycle(6'd0, 1'b0);
    bus2.D_50000 = 1'b0;
    chk("b2_no_note", bus2.note_out, 0);
    cycle(6'd0, 1'b0);
    chk("b2_dep_done", bus2.done, 1);
    chk("b2_dep_stk", bus2.stock, 255);
    chk("b2_dep_code", bus2.err_code, 0);
    chk("b2_dep_bal", bus2.balance, 4);
    bus2.D_50000 = 1'b1;
    cycle(6'd0, 1'b0);
    bus2.D_50000 = 1'b0;
    cycle(6'd0, 1'b0);
    chk("b2_ovf_err", bus2.err, 1);
    chk("b2_ovf_code", bus2.err_code, 3);
    chk("b2_ovf_stk", bus2.stock, 255);
    chk("b2_ovf_bal", bus2.balance, 4);
    chk("b2_ovf_done", bus2.done, 0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
